// File: rtl/cavlc_byte_framer.sv
// cavlc_byte_framer
// Collects each burst of encoded bytes from the cavlc encoder into one bank of
// a two-bank ping-pong buffer, then re-emits every stored burst as a frame
// [SYNC, LEN, payload..., CSUM] on a valid/ready byte stream. The encoder is
// throttled through enc_enable whenever the bank it would write next is still
// waiting to be emitted.

module cavlc_byte_framer #(
    parameter int unsigned MAX_LEN   = 32,     // payload bytes per bank, power of 2
    parameter logic [7:0]  SYNC_BYTE = 8'hA5   // first byte of every frame
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       enc_enable,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       overflow,
    output logic       busy
);

    // Byte address inside a bank, and a count that can also hold MAX_LEN itself.
    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_LEN,
        S_DATA,
        S_CSUM
    } emit_state_t;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [2][MAX_LEN];  // payload bytes, one row per bank
    logic [7:0]    r_len [2];           // payload length of each closed bank
    logic [7:0]    r_fcsum [2];         // finished checksum (len ^ payload) per bank
    logic [1:0]    r_full;              // bank holds a closed burst not yet emitted

    logic [CW-1:0] r_cnt;               // bytes captured into the open bank
    logic [7:0]    r_csum;              // running XOR of the open bank's payload
    logic          r_wsel;              // bank being filled
    logic          r_rsel;              // bank being emitted
    logic          r_overflow;

    emit_state_t   r_state;
    emit_state_t   w_state_nxt;
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] w_rptr_nxt;
    logic          w_release;           // CSUM accepted: hand the bank back

    // ------------------------------------------------------------------
    // Capture-side decode
    // ------------------------------------------------------------------
    logic          w_wr_ok;
    logic          w_wr_en;
    logic          w_drop;
    logic          w_close;
    logic [7:0]    w_cnt8;
    logic [1:0]    w_full_set;
    logic [1:0]    w_full_clr;

    // A byte is stored only if the open bank is free and has room left.
    assign w_wr_ok    = !r_full[r_wsel] && (r_cnt != CNT_MAX);
    assign w_wr_en    = in_valid && w_wr_ok;
    assign w_drop     = in_valid && !w_wr_ok;
    // The first idle cycle after a non-empty burst seals the bank.
    assign w_close    = !in_valid && (r_cnt != '0);
    assign w_cnt8     = 8'(r_cnt);

    assign w_full_set = w_close   ? (2'b01 << r_wsel) : 2'b00;
    assign w_full_clr = w_release ? (2'b01 << r_rsel) : 2'b00;

    // Payload write into the open bank.
    // NOTE: the payload RAM has no reset; a byte is only ever read back after
    // it has been written in the same burst, so its power-up contents never
    // reach m_data, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wsel][r_cnt[AW-1:0]] <= in_data;
        end
    end

    // Byte counting, running checksum, bank close and sticky overflow.
    // NOTE: every clocked block uses non-blocking assignments so that all
    // registers see the values from before the edge, whatever the block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_csum     <= '0;
            r_wsel     <= 1'b0;
            r_overflow <= 1'b0;
            r_len[0]   <= '0;
            r_len[1]   <= '0;
            r_fcsum[0] <= '0;
            r_fcsum[1] <= '0;
        end else begin
            if (w_wr_en) begin
                r_cnt  <= r_cnt + CW'(1);
                r_csum <= r_csum ^ in_data;
            end else if (w_close) begin
                r_len[r_wsel]   <= w_cnt8;
                r_fcsum[r_wsel] <= r_csum ^ w_cnt8;
                r_wsel          <= ~r_wsel;
                r_cnt           <= '0;
                r_csum          <= '0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Bank occupancy: capture sets the bank it closes, the emitter clears the
    // bank it finished; those are always different banks, and clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full | w_full_set) & ~w_full_clr;
        end
    end

    // ------------------------------------------------------------------
    // Emitter
    // ------------------------------------------------------------------

    // Emitter state register, payload read pointer and read-bank select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rptr  <= '0;
            r_rsel  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rptr  <= w_rptr_nxt;
            if (w_release) begin
                r_rsel <= ~r_rsel;
            end
        end
    end

    // Next-state and stream outputs; everything is a function of registered
    // state, so m_data/m_last cannot move while the sink stalls.
    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_rptr_nxt  = r_rptr;
        w_release   = 1'b0;
        m_valid     = 1'b0;
        m_data      = '0;
        m_last      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_full[r_rsel]) begin
                    w_state_nxt = S_SYNC;
                end
            end
            S_SYNC: begin
                m_valid = 1'b1;
                m_data  = SYNC_BYTE;
                if (m_ready) begin
                    w_state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                m_valid = 1'b1;
                m_data  = r_len[r_rsel];
                if (m_ready) begin
                    w_state_nxt = S_DATA;
                    w_rptr_nxt  = '0;
                end
            end
            S_DATA: begin
                m_valid = 1'b1;
                m_data  = r_mem[r_rsel][r_rptr];
                if (m_ready) begin
                    // Stored lengths are always at least 1, so len-1 never wraps.
                    if (8'(r_rptr) == (r_len[r_rsel] - 8'd1)) begin
                        w_state_nxt = S_CSUM;
                    end else begin
                        w_rptr_nxt = r_rptr + AW'(1);
                    end
                end
            end
            S_CSUM: begin
                m_valid = 1'b1;
                m_data  = r_fcsum[r_rsel];
                m_last  = 1'b1;
                if (m_ready) begin
                    // Returning through IDLE leaves a one-cycle gap between frames.
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    assign enc_enable = !r_full[r_wsel];
    assign overflow   = r_overflow;
    assign busy       = (|r_full) || (r_state != S_IDLE);

endmodule

// File: tb/tb_cavlc_byte_framer.sv
// Self-checking bench for cavlc_byte_framer. A frame-level model turns the
// driven bursts into expected frames and tracks how many closed bursts are
// waiting; a negedge compare process checks the stream and status outputs
// against it every cycle. Directed tests add literal expectations.

module tb_cavlc_byte_framer;

    localparam int         MAX_LEN = 32;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       enc_enable;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       overflow;
    logic       busy;

    cavlc_byte_framer #(
        .MAX_LEN  (MAX_LEN),
        .SYNC_BYTE(SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .enc_enable(enc_enable),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .overflow  (overflow),
        .busy      (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Frame-level model state.
    logic [7:0] exp_byte [$];   // bytes of closed frames still to be emitted
    bit         exp_last [$];   // matching "last byte of frame" flags
    logic [7:0] cur [$];        // bytes of the burst currently being collected
    int         stored   = 0;   // closed bursts not yet fully emitted (0..2)
    bit         ovf_exp  = 0;
    bit         gap_due  = 0;   // a frame just ended: the next cycle must be quiet
    logic [7:0] acc_log [$];    // every byte the sink accepted
    bit         mon_full_pre;
    logic [7:0] mon_cs;

    bit rdy_rand  = 0;
    bit rdy_fixed = 1;

    logic [7:0] t2_exp [6] = '{8'hA5, 8'h03, 8'h05, 8'h00, 8'h03, 8'h05};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < acc_log.size()) return 32'(acc_log[i]);
        return 32'hDEAD_BEEF;
    endfunction

    // Compare outputs against the model, then advance the model by the edge
    // that is about to happen, using the inputs and handshake now stable.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_m_valid",    32'(m_valid),    32'd0);
            check("rst_m_last",     32'(m_last),     32'd0);
            check("rst_m_data",     32'(m_data),     32'd0);
            check("rst_enc_enable", 32'(enc_enable), 32'd1);
            check("rst_overflow",   32'(overflow),   32'd0);
            check("rst_busy",       32'(busy),       32'd0);
            exp_byte.delete();
            exp_last.delete();
            cur.delete();
            stored  = 0;
            ovf_exp = 0;
            gap_due = 0;
        end else begin
            check("enc_enable", 32'(enc_enable), 32'(stored != 2));
            check("overflow",   32'(overflow),   32'(ovf_exp));
            check("busy",       32'(busy),       32'(stored != 0));
            if (exp_byte.size() == 0 || gap_due) begin
                check("m_valid_quiet", 32'(m_valid), 32'd0);
            end else if (m_valid) begin
                check("m_data", 32'(m_data), 32'(exp_byte[0]));
                check("m_last", 32'(m_last), 32'(exp_last[0]));
            end

            mon_full_pre = (stored == 2);
            gap_due      = 0;
            if (m_valid && m_ready) begin
                acc_log.push_back(m_data);
                if (exp_byte.size() != 0) begin
                    if (exp_last[0]) begin
                        stored--;
                        gap_due = 1;
                    end
                    void'(exp_byte.pop_front());
                    void'(exp_last.pop_front());
                end
            end

            if (in_valid) begin
                if (mon_full_pre || cur.size() == MAX_LEN) ovf_exp = 1;
                else cur.push_back(in_data);
            end else if (cur.size() != 0) begin
                mon_cs = 8'(cur.size());
                exp_byte.push_back(SYNC);           exp_last.push_back(1'b0);
                exp_byte.push_back(8'(cur.size())); exp_last.push_back(1'b0);
                foreach (cur[i]) begin
                    exp_byte.push_back(cur[i]);
                    exp_last.push_back(1'b0);
                    mon_cs ^= cur[i];
                end
                exp_byte.push_back(mon_cs);         exp_last.push_back(1'b1);
                cur.delete();
                stored++;
            end
        end
    end

    // Sink ready: fixed level or a fresh coin toss each cycle.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
        end
    end

    task automatic drive_byte(input logic [7:0] b);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = b;
    endtask

    task automatic end_burst();
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_byte.size() != 0 || cur.size() != 0 || stored != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 32'(n < 3000), 32'd1);
        idle(2);
    endtask

    task automatic check_t2_frame(input string name);
        check({name, "_size"}, 32'(acc_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_byte%0d", name, i), log_at(i), 32'(t2_exp[i]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int total;
        int len;
        int n;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // T1: reset in the middle of a burst discards it.
        rdy_fixed = 1;
        for (int i = 0; i < 5; i++) drive_byte(8'(8'h30 + i));
        pulse_reset();
        acc_log.delete();
        idle(20);
        check("t1_no_frame",   32'(acc_log.size()), 32'd0);
        check("t1_enc_enable", 32'(enc_enable),     32'd1);
        check("t1_m_valid",    32'(m_valid),        32'd0);
        check("t1_busy",       32'(busy),           32'd0);

        // T2: basic frame and close/SYNC latency.
        acc_log.delete();
        drive_byte(8'h05);
        drive_byte(8'h00);
        drive_byte(8'h03);
        end_burst();                             // byte 03 sampled at this edge
        check("t2_lat_e0", 32'(m_valid), 32'd0);
        idle(1);                                 // close edge
        check("t2_lat_e1", 32'(m_valid), 32'd0);
        idle(1);
        check("t2_lat_e2", 32'(m_valid), 32'd1);
        check("t2_sync",   32'(m_data),  32'hA5);
        drain("t2_drain");
        check_t2_frame("t2");

        // T3: same burst under a random ready pattern.
        acc_log.delete();
        rdy_rand = 1;
        drive_byte(8'h05);
        drive_byte(8'h00);
        drive_byte(8'h03);
        end_burst();
        drain("t3_drain");
        rdy_rand = 0;
        idle(2);
        check_t2_frame("t3");

        // T4: fill both banks against a stalled sink, overflow a third burst.
        acc_log.delete();
        rdy_fixed = 0;
        idle(2);
        for (int i = 1; i <= 4; i++) drive_byte(8'(8'h11 * i));
        end_burst();
        for (int i = 5; i <= 8; i++) drive_byte(8'(8'h11 * i));
        end_burst();
        idle(1);
        check("t4_enc_disabled", 32'(enc_enable), 32'd0);
        check("t4_busy",         32'(busy),       32'd1);
        check("t4_stall_valid",  32'(m_valid),    32'd1);
        check("t4_stall_sync",   32'(m_data),     32'hA5);
        drive_byte(8'h99);
        drive_byte(8'hAA);
        drive_byte(8'hBB);
        end_burst();
        idle(1);
        check("t4_overflow", 32'(overflow), 32'd1);
        rdy_fixed = 1;
        drain("t4_drain");
        check("t4_enc_enabled", 32'(enc_enable), 32'd1);
        check("t4_size",   32'(acc_log.size()), 32'd14);
        check("t4_len1",   log_at(1),  32'h04);
        check("t4_first",  log_at(2),  32'h11);
        check("t4_csum1",  log_at(6),  32'h40);
        check("t4_sync2",  log_at(7),  32'hA5);
        check("t4_second", log_at(9),  32'h55);
        check("t4_csum2",  log_at(13), 32'hC8);

        // T5: 33-byte burst is capped at MAX_LEN.
        pulse_reset();
        acc_log.delete();
        for (int i = 1; i <= 33; i++) drive_byte(8'(i));
        end_burst();
        drain("t5_drain");
        check("t5_overflow", 32'(overflow),       32'd1);
        check("t5_size",     32'(acc_log.size()), 32'd35);
        check("t5_len",      log_at(1),           32'h20);
        check("t5_first",    log_at(2),           32'h01);
        check("t5_lastpay",  log_at(33),          32'h20);
        check("t5_csum",     log_at(34),          32'h00);

        // T6: random bursts, random ready, encoder honours enc_enable.
        pulse_reset();
        acc_log.delete();
        rdy_rand = 1;
        total    = 0;
        for (int f = 0; f < 16; f++) begin
            idle(1);
            n = 0;
            while (!enc_enable && n < 2000) begin
                @(posedge clk); #1;
                n++;
            end
            check("t6_enable_wait", 32'(n < 2000), 32'd1);
            len = $urandom_range(1, 17);
            for (int j = 0; j < len; j++) drive_byte(8'($urandom));
            end_burst();
            total += len + 3;
            idle($urandom_range(0, 3));
        end
        drain("t6_drain");
        rdy_rand = 0;
        idle(2);
        check("t6_overflow", 32'(overflow),       32'd0);
        check("t6_size",     32'(acc_log.size()), 32'(total));

        // T7: reset while a frame is being emitted; nothing resumes.
        rdy_fixed = 0;
        idle(2);
        for (int i = 0; i < 6; i++) drive_byte(8'(8'hC0 + i));
        end_burst();
        idle(4);
        rdy_fixed = 1;
        idle(3);
        pulse_reset();
        acc_log.delete();
        idle(20);
        check("t7_no_resume", 32'(acc_log.size()), 32'd0);
        check("t7_busy",      32'(busy),           32'd0);
        check("t7_enc",       32'(enc_enable),     32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
